// File: rtl/prach_ditfft3_bf1_mc.sv
// prach_ditfft3_bf1_mc
//   First butterfly of the radix-3 DIT FFT in the PRACH long-sequence path.
//   Each frame is 3*NCH consecutive samples: x0[0..NCH-1], x1[0..NCH-1],
//   x2[0..NCH-1]. The outputs come out in the same slot order as
//   x0, x1+x2 and x2-x1, with a fixed latency of NCH+2 cycles. Samples that
//   arrive outside a frame pass through unchanged.
//
//   Parameters
//     WIDTH : input component width (signed)
//     NCH   : interleaved channels per slot group (1..64)
//     OGROW : 1 = WIDTH+1-bit exact output, 0 = WIDTH-bit saturated output
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     din_dr / din_di     input real / imaginary
//     din_dv              valid tag, delayed only
//     sync_in             first sample (x0, ch0) of a frame
//     dout_dr / dout_di   output real / imaginary (WIDTH+OGROW bits)
//     dout_dv, sync_out   din_dv / sync_in delayed by NCH+2
//     frame_err           sync_in arrived inside a frame (aligned with sync_out)
//     ovf                 the current output sample was saturated (OGROW=0)
module prach_ditfft3_bf1_mc #(
  parameter int WIDTH = 18,
  parameter int NCH   = 1,
  parameter int OGROW = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [WIDTH-1:0]       din_dr,
  input  logic signed [WIDTH-1:0]       din_di,
  input  logic                          din_dv,
  input  logic                          sync_in,
  output logic signed [WIDTH+OGROW-1:0] dout_dr,
  output logic signed [WIDTH+OGROW-1:0] dout_di,
  output logic                          dout_dv,
  output logic                          sync_out,
  output logic                          frame_err,
  output logic                          ovf
);

  localparam int SW = WIDTH + 1;
  localparam int OW = WIDTH + OGROW;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MD = 1 << CW;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grp_q, grp_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            ferr_d;
  logic            last_slot;

  logic signed [WIDTH-1:0] dr_p0   [NCH];
  logic signed [WIDTH-1:0] di_p0   [NCH];
  logic                    act_p0  [NCH];
  logic [1:0]              grp_p0  [NCH];
  logic [CW-1:0]           ch_p0   [NCH];
  logic                    vld_p0  [NCH];
  logic                    sync_p0 [NCH];
  logic                    ferr_p0 [NCH];

  logic signed [WIDTH-1:0] x1r_mem [MD];
  logic signed [WIDTH-1:0] x1i_mem [MD];

  logic signed [SW-1:0]    tr, ti, sum_r, sum_i;
  logic signed [SW-1:0]    res_r_p1, res_i_p1;
  logic                    vld_p1, sync_p1, ferr_p1;

  logic signed [OW-1:0]    out_r, out_i;
  logic                    out_ovf;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1] != v[SW-2])
      sat = v[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat = v[WIDTH-1:0];
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] v);
    clips = v[SW-1] ^ v[SW-2];
  endfunction

  // Slot counter: tags the sample currently on din with its group/channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    ch_d      = ch_q;
    ferr_d    = 1'b0;
    last_slot = (state_q == ACTIVE) && (grp_q == 2'd2) && (ch_q == CW'(NCH - 1));
    if (sync_in) begin
      // A sync right after the last slot is a legal back-to-back frame.
      ferr_d  = (state_q == ACTIVE) && !last_slot;
      state_d = ACTIVE;
      grp_d   = 2'd0;
      ch_d    = '0;
    end else if (state_q == ACTIVE && !last_slot) begin
      if (ch_q == CW'(NCH - 1)) begin
        ch_d  = '0;
        grp_d = grp_q + 2'd1;
      end else begin
        ch_d  = ch_q + 1'b1;
      end
    end else begin
      state_d = IDLE;
      grp_d   = 2'd0;
      ch_d    = '0;
    end
  end

  // Stage p0: NCH-deep delay line carrying samples and their slot tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        dr_p0[i]   <= '0;
        di_p0[i]   <= '0;
        act_p0[i]  <= 1'b0;
        grp_p0[i]  <= '0;
        ch_p0[i]   <= '0;
        vld_p0[i]  <= 1'b0;
        sync_p0[i] <= 1'b0;
        ferr_p0[i] <= 1'b0;
      end
    end else begin
      dr_p0[0]   <= din_dr;
      di_p0[0]   <= din_di;
      act_p0[0]  <= (state_d == ACTIVE);
      grp_p0[0]  <= grp_d;
      ch_p0[0]   <= ch_d;
      vld_p0[0]  <= din_dv;
      sync_p0[0] <= sync_in;
      ferr_p0[0] <= ferr_d;
      for (int i = 1; i < NCH; i++) begin
        dr_p0[i]   <= dr_p0[i-1];
        di_p0[i]   <= di_p0[i-1];
        act_p0[i]  <= act_p0[i-1];
        grp_p0[i]  <= grp_p0[i-1];
        ch_p0[i]   <= ch_p0[i-1];
        vld_p0[i]  <= vld_p0[i-1];
        sync_p0[i] <= sync_p0[i-1];
        ferr_p0[i] <= ferr_p0[i-1];
      end
    end
  end

  // x1 store: one entry per channel, read back when x2 of that channel
  // leaves the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MD; i++) begin
        x1r_mem[i] <= '0;
        x1i_mem[i] <= '0;
      end
    end else if (state_d == ACTIVE && grp_d == 2'd1) begin
      x1r_mem[ch_d] <= din_dr;
      x1i_mem[ch_d] <= din_di;
    end
  end

  // When x1[c] leaves the delay line, x2[c] is on din at that same cycle;
  // when x2[c] leaves, x1[c] is in the store.
  always_comb begin
    tr    = SW'(dr_p0[NCH-1]);
    ti    = SW'(di_p0[NCH-1]);
    sum_r = tr;
    sum_i = ti;
    if (act_p0[NCH-1]) begin
      if (grp_p0[NCH-1] == 2'd1) begin
        sum_r = tr + SW'(din_dr);
        sum_i = ti + SW'(din_di);
      end else if (grp_p0[NCH-1] == 2'd2) begin
        sum_r = tr - SW'(x1r_mem[ch_p0[NCH-1]]);
        sum_i = ti - SW'(x1i_mem[ch_p0[NCH-1]]);
      end
    end
  end

  // Stage p1: full-precision butterfly result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r_p1 <= '0;
      res_i_p1 <= '0;
      vld_p1   <= 1'b0;
      sync_p1  <= 1'b0;
      ferr_p1  <= 1'b0;
    end else begin
      res_r_p1 <= sum_r;
      res_i_p1 <= sum_i;
      vld_p1   <= vld_p0[NCH-1];
      sync_p1  <= sync_p0[NCH-1];
      ferr_p1  <= ferr_p0[NCH-1];
    end
  end

  generate
    if (OGROW != 0) begin : g_grow
      assign out_r   = res_r_p1;
      assign out_i   = res_i_p1;
      assign out_ovf = 1'b0;
    end else begin : g_sat
      assign out_r   = sat(res_r_p1);
      assign out_i   = sat(res_i_p1);
      assign out_ovf = clips(res_r_p1) | clips(res_i_p1);
    end
  endgenerate

  // Stage p2: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dr   <= '0;
      dout_di   <= '0;
      dout_dv   <= 1'b0;
      sync_out  <= 1'b0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      dout_dr   <= out_r;
      dout_di   <= out_i;
      dout_dv   <= vld_p1;
      sync_out  <= sync_p1;
      frame_err <= ferr_p1;
      ovf       <= out_ovf;
    end
  end

endmodule

// File: tb/tb_prach_ditfft3_bf1_mc.sv
module tb_prach_ditfft3_bf1_mc;

  localparam int W    = 18;
  localparam int ND   = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic signed [W-1:0] din_dr, din_di;
  logic                din_dv, sync_in;

  logic signed [W:0]   o0r, o0i, o1r, o1i;
  logic signed [W-1:0] o2r, o2i, o3r, o3i;
  logic [ND-1:0]       odv, osy, ofe, oov;

  // 0: NCH=1 grow, 1: NCH=2 grow, 2: NCH=1 saturate, 3: NCH=3 saturate
  prach_ditfft3_bf1_mc #(.WIDTH(W), .NCH(1), .OGROW(1)) u0 (
    .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .dout_dr(o0r), .dout_di(o0i), .dout_dv(odv[0]),
    .sync_out(osy[0]), .frame_err(ofe[0]), .ovf(oov[0]));
  prach_ditfft3_bf1_mc #(.WIDTH(W), .NCH(2), .OGROW(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .dout_dr(o1r), .dout_di(o1i), .dout_dv(odv[1]),
    .sync_out(osy[1]), .frame_err(ofe[1]), .ovf(oov[1]));
  prach_ditfft3_bf1_mc #(.WIDTH(W), .NCH(1), .OGROW(0)) u2 (
    .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .dout_dr(o2r), .dout_di(o2i), .dout_dv(odv[2]),
    .sync_out(osy[2]), .frame_err(ofe[2]), .ovf(oov[2]));
  prach_ditfft3_bf1_mc #(.WIDTH(W), .NCH(3), .OGROW(0)) u3 (
    .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .dout_dr(o3r), .dout_di(o3i), .dout_dv(odv[3]),
    .sync_out(osy[3]), .frame_err(ofe[3]), .ovf(oov[3]));

  int tcur  = 0;
  int n_vec = 0;
  int n_err = 0;

  int in_r [MAXC];
  int in_i [MAXC];
  bit in_s [MAXC];
  bit in_v [MAXC];
  bit rs   [MAXC];
  int ob_r [ND][MAXC];
  int ob_i [ND][MAXC];
  bit ob_v [ND][MAXC];
  bit ob_s [ND][MAXC];
  bit ob_f [ND][MAXC];
  bit ob_o [ND][MAXC];

  int tk [MAXC];
  int tf [MAXC];
  bit fe [MAXC];

  typedef struct {
    int        dut;
    int        n;
    int        xr [12];
    int        xi [12];
    bit [11:0] sy;
    bit [11:0] dc;
    int        er [12];
    int        ei [12];
    bit [11:0] eo;
    bit [11:0] ef;
  } dvec_t;

  dvec_t tv [7];

  function automatic int nch_of(input int d);
    case (d)
      0: nch_of = 1;
      1: nch_of = 2;
      2: nch_of = 1;
      default: nch_of = 3;
    endcase
  endfunction

  function automatic bit og_of(input int d);
    og_of = (d < 2);
  endfunction

  function automatic int rnd();
    case ($urandom_range(0, 3))
      0: rnd = 131071 - int'($urandom_range(0, 2));
      1: rnd = -131072 + int'($urandom_range(0, 2));
      2: rnd = int'($urandom_range(0, 200)) - 100;
      default: rnd = int'($urandom_range(0, 262143)) - 131072;
    endcase
  endfunction

  task automatic step(input int r, input int i, input bit s, input bit v, input bit rs_i);
    if (tcur >= MAXC) begin
      $display("FAIL capture: cycle %0d exceeds buffer of %0d", tcur, MAXC);
      $fatal(1);
    end
    @(posedge clk);
    #1;
    rst_n   = rs_i;
    din_dr  = W'(r);
    din_di  = W'(i);
    sync_in = s;
    din_dv  = v;
    in_r[tcur] = r;
    in_i[tcur] = i;
    in_s[tcur] = s;
    in_v[tcur] = v;
    rs[tcur]   = rs_i;
    @(negedge clk);
    ob_r[0][tcur] = int'(o0r);  ob_i[0][tcur] = int'(o0i);
    ob_r[1][tcur] = int'(o1r);  ob_i[1][tcur] = int'(o1i);
    ob_r[2][tcur] = int'(o2r);  ob_i[2][tcur] = int'(o2i);
    ob_r[3][tcur] = int'(o3r);  ob_i[3][tcur] = int'(o3i);
    for (int d = 0; d < ND; d++) begin
      ob_v[d][tcur] = odv[d];
      ob_s[d][tcur] = osy[d];
      ob_f[d][tcur] = ofe[d];
      ob_o[d][tcur] = oov[d];
    end
    tcur++;
  endtask

  task automatic cmp(input string nm, input int t, input int d, input int er, input int ei,
                     input bit ckd, input bit cko, input bit eo, input bit ev,
                     input bit es, input bit ef);
    bit bad;
    bad = 1'b0;
    n_vec++;
    if (ckd && (ob_r[d][t] != er || ob_i[d][t] != ei)) bad = 1'b1;
    if (cko && ob_o[d][t] != eo) bad = 1'b1;
    if (ob_v[d][t] != ev || ob_s[d][t] != es || ob_f[d][t] != ef) bad = 1'b1;
    if (bad) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got r=%0d i=%0d dv=%0b sync=%0b ferr=%0b ovf=%0b; want r=%0d i=%0d dv=%0b sync=%0b ferr=%0b ovf=%0b (data checked %0b)",
               nm, d, t, ob_r[d][t], ob_i[d][t], ob_v[d][t], ob_s[d][t], ob_f[d][t],
               ob_o[d][t], er, ei, ev, es, ef, eo, ckd);
    end
  endtask

  function automatic int fval(input bit re, input int f, input int k, input int nch);
    int g, c, a, b, x0;
    g  = k / nch;
    c  = k % nch;
    x0 = re ? in_r[f + c]         : in_i[f + c];
    a  = re ? in_r[f + nch + c]   : in_i[f + nch + c];
    b  = re ? in_r[f + 2*nch + c] : in_i[f + 2*nch + c];
    case (g)
      0:       fval = x0;
      1:       fval = a + b;
      default: fval = b - a;
    endcase
  endfunction

  // Offline reference: tags every captured input sample with its frame and
  // slot from the frame rules, then derives each output cycle's expectation.
  task automatic check_model(input int d);
    int nch, lat, last, k, f;
    bit og;
    nch  = nch_of(d);
    og   = og_of(d);
    lat  = nch + 2;
    last = 3*nch - 1;
    k    = -1;
    f    = 0;
    for (int u = 0; u < tcur; u++) begin
      fe[u] = 1'b0;
      tf[u] = 0;
      if (!rs[u]) begin
        k     = -1;
        tk[u] = -2;
      end else begin
        if (in_s[u]) begin
          fe[u] = (k >= 0 && k < last);
          k = 0;
          f = u;
        end else if (k >= 0 && k < last) begin
          k++;
        end else begin
          k = -1;
        end
        tk[u] = k;
        tf[u] = f;
      end
    end
    for (int t = 0; t < tcur; t++) begin
      int u, er, ei, ff;
      bit live, ckd, eo;
      u    = t - lat;
      live = (u >= 0);
      if (live)
        for (int j = u; j <= t; j++)
          if (!rs[j]) live = 1'b0;
      if (!rs[t]) live = 1'b0;
      if (!live) begin
        cmp("model_flush", t, d, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        ckd = 1'b1;
        er  = 0;
        ei  = 0;
        if (tk[u] < 0) begin
          er = in_r[u];
          ei = in_i[u];
        end else begin
          ff = tf[u];
          if (ff + last < tcur && tk[ff + last] == last && tf[ff + last] == ff) begin
            er = fval(1'b1, ff, tk[u], nch);
            ei = fval(1'b0, ff, tk[u], nch);
          end else begin
            ckd = 1'b0;
          end
        end
        eo = 1'b0;
        if (!og && ckd) begin
          if (er > 131071)  begin er = 131071;  eo = 1'b1; end
          if (er < -131072) begin er = -131072; eo = 1'b1; end
          if (ei > 131071)  begin ei = 131071;  eo = 1'b1; end
          if (ei < -131072) begin ei = -131072; eo = 1'b1; end
        end
        cmp("model", t, d, er, ei, ckd, og || ckd, eo, in_v[u], in_s[u], fe[u]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", tcur);
    $fatal(1);
  end

  initial begin
    int ta, t0, lat;
    int pers [8];

    rst_n   = 1'b0;
    din_dr  = '0;
    din_di  = '0;
    din_dv  = 1'b0;
    sync_in = 1'b0;

    tv[0].dut = 0; tv[0].n = 3;
    tv[0].xr = '{5, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[0].xi = '{1, -2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[0].sy = 12'b001; tv[0].dc = '0; tv[0].eo = '0; tv[0].ef = '0;
    tv[0].er = '{5, 10, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[0].ei = '{1, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    tv[1].dut = 1; tv[1].n = 12;
    tv[1].xr = '{1, 2, 10, 20, 3, 4, 1, 2, 10, 20, 3, 4};
    tv[1].xi = '{default: 0};
    tv[1].sy = 12'b000001000001; tv[1].dc = '0; tv[1].eo = '0; tv[1].ef = '0;
    tv[1].er = '{1, 2, 13, 24, -7, -16, 1, 2, 13, 24, -7, -16};
    tv[1].ei = '{default: 0};

    tv[2].dut = 2; tv[2].n = 3;
    tv[2].xr = '{0, 131071, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2].xi = '{default: 0};
    tv[2].sy = 12'b001; tv[2].dc = '0; tv[2].eo = 12'b010; tv[2].ef = '0;
    tv[2].er = '{0, 131071, -131070, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2].ei = '{default: 0};

    tv[3].dut = 2; tv[3].n = 3;
    tv[3].xr = '{0, -131072, 131071, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3].xi = '{default: 0};
    tv[3].sy = 12'b001; tv[3].dc = '0; tv[3].eo = 12'b100; tv[3].ef = '0;
    tv[3].er = '{0, -1, 131071, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3].ei = '{default: 0};

    tv[4].dut = 0; tv[4].n = 3;
    tv[4].xr = '{0, 131071, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4].xi = '{default: 0};
    tv[4].sy = 12'b001; tv[4].dc = '0; tv[4].eo = '0; tv[4].ef = '0;
    tv[4].er = '{0, 131072, -131070, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4].ei = '{default: 0};

    tv[5].dut = 0; tv[5].n = 3;
    tv[5].xr = '{0, -131072, 131071, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[5].xi = '{default: 0};
    tv[5].sy = 12'b001; tv[5].dc = '0; tv[5].eo = '0; tv[5].ef = '0;
    tv[5].er = '{0, -1, 262143, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[5].ei = '{default: 0};

    tv[6].dut = 0; tv[6].n = 4;
    tv[6].xr = '{9, 2, 4, 6, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[6].xi = '{default: 0};
    tv[6].sy = 12'b0011; tv[6].dc = 12'b0001; tv[6].eo = '0; tv[6].ef = 12'b0010;
    tv[6].er = '{0, 2, 10, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[6].ei = '{default: 0};

    // Reset state: inputs are busy while reset is held.
    for (int j = 0; j < 3; j++) step(rnd(), rnd(), 1'b1, 1'b1, 1'b0);
    for (int d = 0; d < ND; d++) cmp("reset_state", 1, d, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed vectors.
    for (int c = 0; c < 7; c++) begin
      t0 = tcur;
      for (int j = 0; j < tv[c].n; j++)
        step(tv[c].xr[j], tv[c].xi[j], tv[c].sy[j], 1'b1, 1'b1);
      for (int p = 0; p < 6; p++) step(0, 0, 1'b0, 1'b0, 1'b1);
      lat = nch_of(tv[c].dut) + 2;
      for (int j = 0; j < tv[c].n; j++)
        cmp($sformatf("vec%0d_slot%0d", c, j), t0 + j + lat, tv[c].dut, tv[c].er[j], tv[c].ei[j],
            !tv[c].dc[j], !tv[c].dc[j], tv[c].eo[j], 1'b1, tv[c].sy[j], tv[c].ef[j]);
    end

    // Reset in the middle of a frame, then a fresh frame right at release.
    ta = tcur;
    step(7, 3, 1'b1, 1'b1, 1'b1);
    step(8, 5, 1'b0, 1'b1, 1'b0);
    step(9, 6, 1'b0, 1'b1, 1'b0);
    step(1, 0, 1'b1, 1'b1, 1'b1);
    step(1, 0, 1'b0, 1'b1, 1'b1);
    step(1, 0, 1'b0, 1'b1, 1'b1);
    for (int p = 0; p < 6; p++) step(0, 0, 1'b0, 1'b0, 1'b1);
    for (int j = 1; j <= 5; j++)
      cmp("mid_reset_zero", ta + j, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("post_reset_x0",  ta + 6, 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("post_reset_sum", ta + 7, 0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("post_reset_dif", ta + 8, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized stream: sync periods matched and mismatched to each NCH,
    // random syncs, and one short reset pulse.
    pers = '{3, 6, 9, 18, 0, 9, 3, 0};
    for (int b = 0; b < 8; b++) begin
      for (int n = 0; n < 60; n++) begin
        bit s, r;
        s = (pers[b] != 0) ? ((n % pers[b]) == 0) : ($urandom_range(0, 6) == 0);
        r = !(b == 5 && (n == 20 || n == 21));
        step(rnd(), rnd(), s, ($urandom_range(0, 1) == 1), r);
      end
    end
    for (int p = 0; p < 8; p++) step(0, 0, 1'b0, 1'b0, 1'b1);

    for (int d = 0; d < ND; d++) check_model(d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prach_ditfft3_bf1_mc.md
# prach_ditfft3_bf1_mc

Parametrised, multi-channel first butterfly of the radix-3 DIT FFT in the PRACH long-sequence path. It takes time-interleaved 3-point groups (x0, x1, x2, each carrying NCH channels back-to-back) and emits x0, x1+x2 and x2−x1 in the same slot order, at a fixed latency. It adds configurable width, selectable bit growth or saturation, and frame-error and overflow flags. It sits between the input reorder buffer and the twiddle/second-butterfly stage.

## Interface
- WIDTH, 18: input component width, signed two's complement.
- NCH, 1: interleaved channels per slot, 1..64.
- OGROW, 1: 1 = output WIDTH+1 bits, exact; 0 = output WIDTH bits, saturated.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din_dr / din_di  in  WIDTH  input real / imaginary.
- din_dv  in  1  input valid tag, delayed only, not used for gating.
- sync_in  in  1  marks the first sample (x0, ch0) of a frame.
- dout_dr / dout_di  out  WIDTH+OGROW  output real / imaginary.
- dout_dv  out  1  din_dv delayed by L.
- sync_out  out  1  sync_in delayed by L.
- frame_err  out  1  one-cycle pulse: sync_in arrived inside a frame.
- ovf  out  1  one-cycle pulse, aligned with the dout sample that saturated (OGROW=0 only; tied 0 otherwise).

## Operation
- Frame: 3·NCH samples on consecutive cycles. Slot index k = 0..3·NCH−1; group g = k / NCH; channel c = k mod NCH.
- Input order: x0[0..NCH−1], x1[0..NCH−1], x2[0..NCH−1].
- Output order matches: g=0 → x0[c]; g=1 → x1[c]+x2[c]; g=2 → x2[c]−x1[c].
- Slot counter states: IDLE, then ACTIVE(k).
  - sync_in in IDLE → ACTIVE(0).
  - ACTIVE(3·NCH−1) with no sync → IDLE.
  - sync_in in ACTIVE(k), any k → ACTIVE(0) and frame_err pulse L cycles later, aligned with sync_out.
  - sync_in at ACTIVE(3·NCH−1) is a legal back-to-back frame: no error.
- Samples that arrive in IDLE pass through unchanged (sign-extended when OGROW=1) with latency L.
- Abandoned-frame outputs are don't-care data. dout_dv and sync_out still follow their inputs.
- x1 per channel is held in an NCH-deep store (register array, or distributed RAM for NCH>8). x0 and the pass-through samples go through an L-deep delay line.
- Arithmetic:
  - Sums are computed at WIDTH+1 bits with full sign extension.
  - OGROW=1: output the full result; x0 is sign-extended.
  - OGROW=0: clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; ovf=1 on that output cycle. x0 never saturates.
- din_dv does not gate anything. Frames must be gap-free.

## Timing
- Latency L = NCH+2 cycles from input slot k to output slot k, for every slot. With NCH=1, L=3.
- Throughput: one complex sample per clock, no stalls.
- Reset (asynchronous assert, synchronous release):
  - counter → IDLE.
  - dout_dr, dout_di, dout_dv, sync_out, frame_err, ovf → 0.
  - Delay lines and x1 store are flushed to 0.
- Reset mid-frame: the frame is lost. The first outputs after release are 0 for L cycles, and dout_dv stays 0 for those cycles.
- The first sync_in after reset is never flagged as an error.

## Test plan
- NCH=1, WIDTH=18, OGROW=1: frame (5,3,7), imag (1,−2,4) → real 5,10,4 and imag 1,2,6 on cycles 3,4,5 after sync. sync_out is at cycle 3.
- NCH=2: x0=(1,2), x1=(10,20), x2=(3,4), real only → dout 1,2,13,24,−7,−16, starting 4 cycles after sync. Back-to-back second frame processes correctly with no frame_err.
- OGROW=0, WIDTH=18:
  - x1=131071, x2=1 → outputs 131071 (sat, ovf=1) and −131070 (ovf=0).
  - x1=−131072, x2=131071 → x1+x2 = −1; x2−x1 saturates to 131071 with ovf=1.
- OGROW=1, same extremes → 131072, −131070, −1 and 262143 exact, ovf stays 0.
- sync_in at slot 1 of a frame (NCH=1) → frame_err pulse coincident with the second sync_out. The restarted frame (2,4,6) gives 2,10,2.
- rst_n low at slot 1, released 2 cycles later → all outputs 0 during reset and for 3 cycles after release. The next frame (1,1,1) gives 1,2,0.
